// File: rtl/simon_cfg_ctrl_if.sv
// AXI4-Lite configuration bus bundle for the Simon sequencer.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs of each channel.
interface simon_cfg_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arcache, arprot, arvalid, rready,
    output awaddr, awcache, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arcache, arprot, arvalid, rready,
    input  awaddr, awcache, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/simon_cfg_ctrl.sv
// AXI4-Lite config slave + one-shot launch sequencer for the Simon round core (IRQ via SIMON_CFG_IRQ_EN).
// Latency: START accept -> core_start next cycle; B/R responses the cycle after accept.
// Backpressure: one outstanding write and one outstanding read; new accepts stall while bvalid/rvalid pend.
module simon_cfg_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int BLOCK_WIDTH = 64,
  parameter int KEY_WIDTH   = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  simon_cfg_ctrl_if.slave        axi_config,
  output logic                   core_start,
  output logic                   core_decrypt,
  output logic [KEY_WIDTH-1:0]   core_key,
  output logic [BLOCK_WIDTH-1:0] core_din,
  input  logic                   core_done,
  input  logic [BLOCK_WIDTH-1:0] core_dout
`ifdef SIMON_CFG_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0][31:0] key_q;
  logic [1:0][31:0] din_q;
  logic [1:0][31:0] dout_q;
  logic            decrypt_q, done_q, err_q, ie_q;
  logic            bvalid_q, rvalid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [31:0]     rdata_q;

  logic            busy, wr_acc, rd_acc, done_evt;
  logic [3:0]      widx, ridx;
  logic [1:0]      wr_resp, rd_resp;
  logic [31:0]     rd_dat;
  logic            cfg_we, status_we, start_req, err_set;
  logic            unused_bits;

  // Cache/prot are don't-care and only addr[5:2] selects a register.
  assign unused_bits = ^{axi_config.arcache, axi_config.arprot, axi_config.awcache,
                         axi_config.awprot, axi_config.araddr, axi_config.awaddr};

  assign busy     = (state_q != S_IDLE);
  assign wr_acc   = axi_config.awvalid & axi_config.wvalid & ~bvalid_q;
  assign rd_acc   = axi_config.arvalid & ~rvalid_q;
  assign widx     = axi_config.awaddr[5:2];
  assign ridx     = axi_config.araddr[5:2];
  assign done_evt = (state_q == S_WAIT) & core_done;

  assign axi_config.awready = wr_acc;
  assign axi_config.wready  = wr_acc;
  assign axi_config.bvalid  = bvalid_q;
  assign axi_config.bresp   = bresp_q;
  assign axi_config.arready = ~rvalid_q;
  assign axi_config.rvalid  = rvalid_q;
  assign axi_config.rresp   = rresp_q;
  assign axi_config.rdata   = rdata_q;

  assign core_decrypt = decrypt_q;
  assign core_key     = key_q;
  assign core_din     = din_q;

`ifdef SIMON_CFG_IRQ_EN
  assign irq = done_q & ie_q;
`else
  assign ie_q = 1'b0;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Write decode: classify the accepted write and flag side effects.
  always_comb begin
    wr_resp   = RESP_OKAY;
    cfg_we    = 1'b0;
    status_we = 1'b0;
    start_req = 1'b0;
    err_set   = 1'b0;
    case (widx)
      4'd0: begin
        if (busy) begin
          wr_resp = RESP_SLVERR;
          err_set = wr_acc & axi_config.wstrb[0] & axi_config.wdata[0];
        end else begin
          cfg_we    = wr_acc;
          start_req = wr_acc & axi_config.wstrb[0] & axi_config.wdata[0];
        end
      end
      4'd1: status_we = wr_acc;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        if (busy) wr_resp = RESP_SLVERR;
        else      cfg_we  = wr_acc;
      end
      4'd8, 4'd9: wr_resp = RESP_SLVERR;
      default:    wr_resp = RESP_DECERR;
    endcase
  end

  // Read decode: select readback word and response for the presented address.
  always_comb begin
    rd_dat  = 32'h0;
    rd_resp = RESP_OKAY;
    case (ridx)
      4'd0:                     rd_dat = {29'h0, ie_q, decrypt_q, 1'b0};
      4'd1:                     rd_dat = {29'h0, err_q, done_q, busy};
      4'd2, 4'd3, 4'd4, 4'd5:   rd_dat = key_q[ridx[1:0] - 2'd2];
      4'd6, 4'd7:               rd_dat = din_q[ridx[0]];
      4'd8, 4'd9:               rd_dat = dout_q[ridx[0]];
      default:                  rd_resp = RESP_DECERR;
    endcase
  end

  // Sequencer next state and launch pulse.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    case (state_q)
      S_IDLE:   if (start_req) state_d = S_LAUNCH;
      S_LAUNCH: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT:   if (core_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Config/status registers; completion set beats a same-edge DONE clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      decrypt_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SIMON_CFG_IRQ_EN
      ie_q      <= 1'b0;
`endif
    end else begin
      if (cfg_we) begin
        case (widx)
          4'd0: if (axi_config.wstrb[0]) begin
            decrypt_q <= axi_config.wdata[1];
`ifdef SIMON_CFG_IRQ_EN
            ie_q      <= axi_config.wdata[2];
`endif
          end
          4'd2, 4'd3, 4'd4, 4'd5:
            key_q[widx[1:0] - 2'd2] <= merge(key_q[widx[1:0] - 2'd2], axi_config.wdata,
                                             axi_config.wstrb);
          4'd6, 4'd7:
            din_q[widx[0]] <= merge(din_q[widx[0]], axi_config.wdata, axi_config.wstrb);
          default: ;
        endcase
      end
      if (done_evt) begin
        dout_q <= core_dout;
        done_q <= 1'b1;
      end else if (start_req) begin
        done_q <= 1'b0;
      end else if (status_we && axi_config.wstrb[0] && axi_config.wdata[1]) begin
        done_q <= 1'b0;
      end
      if (err_set)
        err_q <= 1'b1;
      else if (status_we && axi_config.wstrb[0] && axi_config.wdata[2])
        err_q <= 1'b0;
    end
  end

  // Write response channel: one pending response held until bready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (wr_acc) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp;
    end else if (axi_config.bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read data channel: registered data held until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= 32'h0;
    end else if (rd_acc) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_resp;
      rdata_q  <= rd_dat;
    end else if (axi_config.rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simon_cfg_ctrl.sv
// Directed bench for simon_cfg_ctrl with a response scoreboard and a simple core model.
// Latency: checks START->core_start and core_done->STATUS timing.
// Backpressure: holds rready/bready low to verify held responses and blocked accepts.
module tb_simon_cfg_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         core_start, core_decrypt;
  logic         core_done = 1'b0;
  logic [127:0] core_key;
  logic [63:0]  core_din;
  logic [63:0]  core_dout = 64'h0;
`ifdef SIMON_CFG_IRQ_EN
  logic         irq;
`endif

  int n_cmp = 0, n_err = 0;
  int cyc = 0, start_cnt = 0, start_cyc = -1, acc_cyc = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  simon_cfg_ctrl_if #(.ADDR_WIDTH(8)) axi_config ();

  simon_cfg_ctrl #(.ADDR_WIDTH(8), .BLOCK_WIDTH(64), .KEY_WIDTH(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .axi_config   (axi_config),
    .core_start   (core_start),
    .core_decrypt (core_decrypt),
    .core_key     (core_key),
    .core_din     (core_din),
    .core_done    (core_done),
    .core_dout    (core_dout)
`ifdef SIMON_CFG_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (core_start) begin start_cnt++; start_cyc = cyc; end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic axi_wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                        input logic [1:0] eresp, input logic [3:0] st = 4'hF, input int hold = 0);
    int n;
    logic [1:0] e;
    exp_b.push_back(eresp);
    axi_config.awaddr = a; axi_config.wdata = d; axi_config.wstrb = st;
    axi_config.awvalid = 1'b1; axi_config.wvalid = 1'b1;
    #1;
    n = 0;
    while (!(axi_config.awready && axi_config.wready) && n < 20) begin step(1); n++; end
    chk({tag, "_aw_accept"}, 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    axi_config.awvalid = 1'b0; axi_config.wvalid = 1'b0;
    n = 0;
    while (!axi_config.bvalid && n < 20) begin step(1); n++; end
    chk({tag, "_bvalid"}, 64'(axi_config.bvalid), 64'd1);
    if (hold > 0) begin
      axi_config.awaddr = 8'h20; axi_config.wdata = 32'h0; axi_config.wstrb = 4'hF;
      axi_config.awvalid = 1'b1; axi_config.wvalid = 1'b1;
      #1;
      for (int i = 0; i < hold; i++) begin
        chk({tag, "_b_hold"}, {62'h0, axi_config.bvalid, axi_config.awready}, 64'h2);
        step(1);
      end
      axi_config.awvalid = 1'b0; axi_config.wvalid = 1'b0;
    end
    chk({tag, "_b_sb"}, 64'(exp_b.size() != 0), 64'd1);
    e = (exp_b.size() != 0) ? exp_b.pop_front() : 2'bxx;
    chk({tag, "_bresp"}, 64'(axi_config.bresp), 64'(e));
    axi_config.bready = 1'b1;
    step(1);
    axi_config.bready = 1'b0;
  endtask

  task automatic axi_rd(input string tag, input logic [7:0] a, input logic [31:0] edata,
                        input logic [1:0] eresp, input int hold = 0);
    int n;
    logic [33:0] e;
    exp_r.push_back({eresp, edata});
    axi_config.araddr = a; axi_config.arvalid = 1'b1;
    #1;
    n = 0;
    while (!axi_config.arready && n < 20) begin step(1); n++; end
    chk({tag, "_ar_accept"}, 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    axi_config.arvalid = 1'b0;
    n = 0;
    while (!axi_config.rvalid && n < 20) begin step(1); n++; end
    chk({tag, "_rvalid"}, 64'(axi_config.rvalid), 64'd1);
    if (hold > 0) begin
      axi_config.araddr = 8'h04; axi_config.arvalid = 1'b1;
      #1;
      for (int i = 0; i < hold; i++) begin
        chk({tag, "_r_hold"}, {62'h0, axi_config.rvalid, axi_config.arready}, 64'h2);
        step(1);
      end
      axi_config.arvalid = 1'b0;
    end
    chk({tag, "_r_sb"}, 64'(exp_r.size() != 0), 64'd1);
    e = (exp_r.size() != 0) ? exp_r.pop_front() : 34'bx;
    chk({tag, "_rdata"}, 64'({axi_config.rresp, axi_config.rdata}), 64'(e));
    axi_config.rready = 1'b1;
    step(1);
    axi_config.rready = 1'b0;
  endtask

  task automatic pulse_done(input logic [63:0] dout);
    core_dout = dout; core_done = 1'b1;
    step(1);
    core_done = 1'b0;
  endtask

  initial begin
    axi_config.araddr = '0; axi_config.arcache = '0; axi_config.arprot = '0;
    axi_config.arvalid = 1'b0; axi_config.rready = 1'b0;
    axi_config.awaddr = '0; axi_config.awcache = '0; axi_config.awprot = '0;
    axi_config.awvalid = 1'b0; axi_config.wdata = '0; axi_config.wstrb = '0;
    axi_config.wvalid = 1'b0; axi_config.bready = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_core_key", core_key[63:0] | core_key[127:64], 64'd0);
    chk("rst_core_din", core_din, 64'd0);
    chk("rst_core_decrypt", 64'(core_decrypt), 64'd0);
    chk("rst_valids", {62'h0, axi_config.rvalid, axi_config.bvalid}, 64'd0);
`ifdef SIMON_CFG_IRQ_EN
    chk("rst_irq", 64'(irq), 64'd0);
`endif
    axi_rd("rst_status", 8'h04, 32'h0, 2'b00);

    // Load key / block, launch encrypt
    axi_wr("key0", 8'h08, 32'h03020100, 2'b00);
    axi_wr("key1", 8'h0C, 32'h0B0A0908, 2'b00);
    axi_wr("key2", 8'h10, 32'h13121110, 2'b00);
    axi_wr("key3", 8'h14, 32'h1B1A1918, 2'b00);
    axi_wr("din0", 8'h18, 32'h20646e75, 2'b00);
    axi_wr("din1", 8'h1C, 32'h656b696c, 2'b00);
    axi_rd("key2_rb", 8'h10, 32'h13121110, 2'b00);
    axi_wr("start1", 8'h00, 32'h1, 2'b00);
    chk("start1_latency", 64'(start_cyc), 64'(acc_cyc));
    chk("start1_count", 64'(start_cnt), 64'd1);
    chk("core_key", core_key[63:0], 64'h0B0A0908_03020100);
    chk("core_key_hi", core_key[127:64], 64'h1B1A1918_13121110);
    chk("core_din", core_din, 64'h656b696c_20646e75);
    chk("core_decrypt_enc", 64'(core_decrypt), 64'd0);
    axi_rd("status_busy", 8'h04, 32'h1, 2'b00);

    // Core completes 40 cycles after launch
    while (cyc < start_cyc + 40) step(1);
    pulse_done(64'h44c8fc20_b9dfa07a);
    axi_rd("status_done", 8'h04, 32'h2, 2'b00);
    axi_rd("dout0", 8'h20, 32'hb9dfa07a, 2'b00);
    axi_rd("dout1", 8'h24, 32'h44c8fc20, 2'b00);

    // Error responses and backpressure
    axi_rd("decerr_rd", 8'h3C, 32'h0, 2'b11, 5);
    axi_wr("decerr_wr", 8'h3C, 32'h1234, 2'b11);
    axi_wr("dout_wr", 8'h20, 32'hDEADBEEF, 2'b10, 4'hF, 5);
    axi_rd("dout0_kept", 8'h20, 32'hb9dfa07a, 2'b00);
    axi_wr("key1_strb", 8'h0C, 32'hAAAAAAAA, 2'b00, 4'b0010);
    axi_rd("key1_strb_rb", 8'h0C, 32'h0B0AAA08, 2'b00);
    axi_wr("clr_done", 8'h04, 32'h2, 2'b00);
    axi_rd("status_clr", 8'h04, 32'h0, 2'b00);

    // Second launch (decrypt) and busy protection
    axi_wr("start2", 8'h00, 32'h3, 2'b00);
    chk("start2_count", 64'(start_cnt), 64'd2);
    chk("core_decrypt_dec", 64'(core_decrypt), 64'd1);
    axi_wr("busy_key0", 8'h08, 32'hFFFFFFFF, 2'b10);
    axi_wr("busy_start", 8'h00, 32'h1, 2'b10);
    axi_rd("busy_key0_rb", 8'h08, 32'h03020100, 2'b00);
    axi_rd("busy_status", 8'h04, 32'h5, 2'b00);
    step(3);
    chk("busy_no_restart", 64'(start_cnt), 64'd2);
    axi_wr("busy_clr_err", 8'h04, 32'h4, 2'b00);
    axi_rd("busy_status2", 8'h04, 32'h1, 2'b00);

    // Reset while waiting on the core
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("mid_rst_key", core_key[63:0] | core_key[127:64], 64'd0);
    chk("mid_rst_din", core_din, 64'd0);
    chk("mid_rst_decrypt", 64'(core_decrypt), 64'd0);
    chk("mid_rst_valids", {62'h0, axi_config.rvalid, axi_config.bvalid}, 64'd0);
    axi_rd("mid_rst_status", 8'h04, 32'h0, 2'b00);
    axi_rd("mid_rst_dout0", 8'h20, 32'h0, 2'b00);
    pulse_done(64'h1111_2222_3333_4444);
    axi_rd("idle_done_ignored", 8'h04, 32'h0, 2'b00);

    // Third launch with IE; DONE clear on the completion edge loses
    axi_wr("start3", 8'h00, 32'h5, 2'b00);
    chk("start3_count", 64'(start_cnt), 64'd3);
`ifdef SIMON_CFG_IRQ_EN
    axi_rd("ctrl_ie", 8'h00, 32'h4, 2'b00);
    chk("irq_busy", 64'(irq), 64'd0);
`else
    axi_rd("ctrl_ie", 8'h00, 32'h0, 2'b00);
`endif
    step(4);
    exp_b.push_back(2'b00);
    axi_config.awaddr = 8'h04; axi_config.wdata = 32'h2; axi_config.wstrb = 4'hF;
    axi_config.awvalid = 1'b1; axi_config.wvalid = 1'b1;
    core_dout = 64'h0123_4567_89AB_CDEF; core_done = 1'b1;
    step(1);
    core_done = 1'b0; axi_config.awvalid = 1'b0; axi_config.wvalid = 1'b0;
    chk("setwins_bvalid", 64'(axi_config.bvalid), 64'd1);
    chk("setwins_bresp", 64'(axi_config.bresp), 64'(exp_b.pop_front()));
    axi_config.bready = 1'b1;
    step(1);
    axi_config.bready = 1'b0;
    axi_rd("setwins_status", 8'h04, 32'h2, 2'b00);
`ifdef SIMON_CFG_IRQ_EN
    chk("irq_set", 64'(irq), 64'd1);
`endif
    axi_wr("clr_done3", 8'h04, 32'h2, 2'b00);
    axi_rd("status_final", 8'h04, 32'h0, 2'b00);
`ifdef SIMON_CFG_IRQ_EN
    chk("irq_clr", 64'(irq), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
